// File: rtl/xif_copro_pkg.sv
// Shared types for the XIF coprocessor result stage: XIF result payload, source
// tags/metadata, and the mapping of each source onto the XIF result channel.
package xif_copro_pkg;

    localparam int X_ID_WIDTH  = 4;
    localparam int X_RFW_WIDTH = 32;

    typedef enum logic {SrcExec = 1'b0, SrcMem = 1'b1} result_src_e;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            addr;
        logic                  rd_is_copro;
    } copro_tag_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
        logic                  dbg;
    } mem_metadata_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic [2:0]             ecswe;
        logic [5:0]             ecsdata;
        logic                   exc;
        logic [5:0]             exccode;
        logic                   err;
        logic                   dbg;
    } x_result_t;

    typedef struct packed {
        copro_tag_t             tag;
        logic [X_RFW_WIDTH-1:0] data;
    } copro_result_t;

    // A coprocessor-destined result still reports to the core, but with we=0.
    function automatic x_result_t map_ex(input copro_result_t r);
        x_result_t x;
        x      = '0;
        x.id   = r.tag.id;
        x.data = r.data;
        x.rd   = r.tag.addr;
        x.we   = !r.tag.rd_is_copro;
        return x;
    endfunction

    function automatic x_result_t map_mem(input mem_metadata_t m, input logic [X_RFW_WIDTH-1:0] d);
        x_result_t x;
        x         = '0;
        x.id      = m.id;
        x.rd      = m.rd;
        x.we      = m.we & !m.exc;
        x.data    = m.we ? d : '0;
        x.exc     = m.exc;
        x.exccode = m.exc ? m.exccode : '0;
        x.dbg     = m.dbg;
        return x;
    endfunction

endpackage

// File: rtl/xif_copro_result_stage_arb.sv
// Two-requester arbiter (EX vs MEM) with a last-grant pointer that only moves
// when the granted request actually transfers; optional fixed MEM priority.
module xif_copro_rr_arb2
    import xif_copro_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_ex_i,
    input  logic req_mem_i,
    input  logic upd_i,
    output logic gnt_ex_o,
    output logic gnt_mem_o
);

    result_src_e r_last;
    result_src_e w_pick;

    // NOTE: default assigned first so every path through the block drives w_pick (no latch).
    always_comb begin
        w_pick = SrcExec;
        if (req_mem_i && (!req_ex_i || FIXED_PRIO || r_last == SrcExec))
            w_pick = SrcMem;
    end

    assign gnt_ex_o  = req_ex_i  && (w_pick == SrcExec);
    assign gnt_mem_o = req_mem_i && (w_pick == SrcMem);

    // Out of reset the pointer reads "MEM went last", so EX wins the first tie.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_last <= SrcMem;
        else if (upd_i)
            r_last <= w_pick;
    end

endmodule

// File: rtl/xif_copro_result_stage.sv
// Final XIF coprocessor stage: merges execution results and memory completions
// into one registered XIF result channel and writes the coprocessor RF.
module xif_copro_result_stage
    import xif_copro_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  copro_tag_t            ex_tag_i,
    input  logic [DATA_WIDTH-1:0] ex_data_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  mem_metadata_t         mem_meta_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output x_result_t             result_o,
    output logic                  creg_we_o,
    output logic [4:0]            creg_waddr_o,
    output logic [DATA_WIDTH-1:0] creg_wdata_o
);

    logic                  r_valid;
    x_result_t             r_result;
    logic                  r_creg_we;
    logic [4:0]            r_creg_waddr;
    logic [DATA_WIDTH-1:0] r_creg_wdata;

    logic                  w_slot_free;
    logic                  w_gnt_ex;
    logic                  w_gnt_mem;
    logic                  w_ex_fire;
    logic                  w_mem_fire;
    logic                  w_fire;
    logic                  w_creg_fire;
    logic [ID_WIDTH-1:0]   w_ex_id;
    copro_result_t         w_ex_in;
    x_result_t             w_next;

    assign w_slot_free = !r_valid || result_ready_i;

    xif_copro_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO != 0)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_ex_i  (ex_valid_i),
        .req_mem_i (mem_valid_i),
        .upd_i     (w_fire),
        .gnt_ex_o  (w_gnt_ex),
        .gnt_mem_o (w_gnt_mem)
    );

    assign ex_ready_o  = w_gnt_ex  && w_slot_free;
    assign mem_ready_o = w_gnt_mem && w_slot_free;
    assign w_ex_fire   = ex_valid_i  && ex_ready_o;
    assign w_mem_fire  = mem_valid_i && mem_ready_o;
    assign w_fire      = w_ex_fire || w_mem_fire;
    assign w_creg_fire = w_ex_fire && ex_tag_i.rd_is_copro;

    assign w_ex_id      = ex_tag_i.id;
    assign w_ex_in.tag  = '{id: w_ex_id, addr: ex_tag_i.addr, rd_is_copro: ex_tag_i.rd_is_copro};
    assign w_ex_in.data = ex_data_i;
    assign w_next       = w_mem_fire ? map_mem(mem_meta_i, mem_data_i) : map_ex(w_ex_in);

    // The RF write bypasses the result register so back-pressure never delays it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_creg_we    <= 1'b0;
            r_creg_waddr <= '0;
            r_creg_wdata <= '0;
        end else begin
            if (w_fire) begin
                r_valid  <= 1'b1;
                r_result <= w_next;
            end else if (result_ready_i) begin
                r_valid  <= 1'b0;
            end
            r_creg_we <= w_creg_fire;
            if (w_creg_fire) begin
                r_creg_waddr <= ex_tag_i.addr;
                r_creg_wdata <= ex_data_i;
            end
        end
    end

    assign result_valid_o = r_valid;
    assign result_o       = r_result;
    assign creg_we_o      = r_creg_we;
    assign creg_waddr_o   = r_creg_waddr;
    assign creg_wdata_o   = r_creg_wdata;

endmodule

// File: tb/tb_xif_copro_result_stage.sv
// Directed bench: a driver issues vectors and queues expected results; monitors
// compare XIF results and coprocessor RF writes as the DUT presents them.
module tb_xif_copro_result_stage;
    import xif_copro_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ex_valid_i = 1'b0;
    logic          ex_ready_o;
    copro_tag_t    ex_tag_i = '0;
    logic [31:0]   ex_data_i = '0;
    logic          mem_valid_i = 1'b0;
    logic          mem_ready_o;
    mem_metadata_t mem_meta_i = '0;
    logic [31:0]   mem_data_i = '0;
    logic          result_valid_o;
    logic          result_ready_i = 1'b1;
    x_result_t     result_o;
    logic          creg_we_o;
    logic [4:0]    creg_waddr_o;
    logic [31:0]   creg_wdata_o;

    logic          fp_ex_valid = 1'b0;
    logic          fp_ex_ready;
    copro_tag_t    fp_ex_tag = '0;
    logic [31:0]   fp_ex_data = '0;
    logic          fp_mem_valid = 1'b0;
    logic          fp_mem_ready;
    mem_metadata_t fp_mem_meta = '0;
    logic [31:0]   fp_mem_data = '0;
    logic          fp_result_valid;
    logic          fp_result_ready = 1'b1;
    x_result_t     fp_result;
    logic          fp_creg_we;
    logic [4:0]    fp_creg_waddr;
    logic [31:0]   fp_creg_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    x_result_t   exp_q[$];
    logic [36:0] creg_q[$];

    always #5 clk_i = ~clk_i;

    xif_copro_result_stage #(.ID_WIDTH(4), .DATA_WIDTH(32), .FIXED_PRIO(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_tag_i(ex_tag_i), .ex_data_i(ex_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_meta_i(mem_meta_i), .mem_data_i(mem_data_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_o(result_o),
        .creg_we_o(creg_we_o), .creg_waddr_o(creg_waddr_o), .creg_wdata_o(creg_wdata_o)
    );

    xif_copro_result_stage #(.ID_WIDTH(4), .DATA_WIDTH(32), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(fp_ex_valid), .ex_ready_o(fp_ex_ready), .ex_tag_i(fp_ex_tag), .ex_data_i(fp_ex_data),
        .mem_valid_i(fp_mem_valid), .mem_ready_o(fp_mem_ready), .mem_meta_i(fp_mem_meta), .mem_data_i(fp_mem_data),
        .result_valid_o(fp_result_valid), .result_ready_i(fp_result_ready), .result_o(fp_result),
        .creg_we_o(fp_creg_we), .creg_waddr_o(fp_creg_waddr), .creg_wdata_o(fp_creg_wdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic x_result_t mk(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                                     input logic we, input logic exc, input logic [5:0] code, input logic dbg);
        x_result_t x;
        x         = '0;
        x.id      = id;
        x.data    = data;
        x.rd      = rd;
        x.we      = we;
        x.exc     = exc;
        x.exccode = code;
        x.dbg     = dbg;
        return x;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (result_valid_o && result_ready_i) begin
                if (exp_q.size() == 0) check("unexpected_result", result_o, 64'h0)
                    ;
                else check("result", result_o, exp_q.pop_front());
            end
            if (creg_we_o) begin
                if (creg_q.size() == 0) check("unexpected_creg_we", {creg_waddr_o, creg_wdata_o}, 64'h0);
                else check("creg_write", {creg_waddr_o, creg_wdata_o}, creg_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_ex(input logic [3:0] id, input logic [4:0] addr, input logic copro, input logic [31:0] d);
        logic acc;
        acc        = 1'b0;
        ex_valid_i = 1'b1;
        ex_tag_i   = '{id: id, addr: addr, rd_is_copro: copro};
        ex_data_i  = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk_i);
            acc = ex_ready_o;
            tick();
        end
        ex_valid_i = 1'b0;
        if (!acc) check("ex_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_mem(input mem_metadata_t m, input logic [31:0] d);
        logic acc;
        acc         = 1'b0;
        mem_valid_i = 1'b1;
        mem_meta_i  = m;
        mem_data_i  = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk_i);
            acc = mem_ready_o;
            tick();
        end
        mem_valid_i = 1'b0;
        if (!acc) check("mem_accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        copro_tag_t    ex_items [2];
        logic [31:0]   ex_dat   [2];
        mem_metadata_t mem_items[2];
        logic [31:0]   mem_dat  [2];
        int            ei, mi, cyc;
        logic          ae, am;

        // Reset state
        #2;
        check("rst_result_valid", result_valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_creg", {creg_we_o, creg_waddr_o, creg_wdata_o}, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // Both sources valid, round-robin: EX, MEM, EX, MEM in 4 cycles
        ex_items[0]  = '{id: 4'd1, addr: 5'd4, rd_is_copro: 1'b0}; ex_dat[0] = 32'hAAAA0001;
        ex_items[1]  = '{id: 4'd3, addr: 5'd6, rd_is_copro: 1'b0}; ex_dat[1] = 32'h00000003;
        mem_items[0] = '{id: 4'd2, rd: 5'd3, we: 1'b1, exc: 1'b0, exccode: 6'd0, dbg: 1'b0}; mem_dat[0] = 32'h11111111;
        mem_items[1] = '{id: 4'd4, rd: 5'd8, we: 1'b0, exc: 1'b0, exccode: 6'd0, dbg: 1'b1}; mem_dat[1] = 32'h0000DEAD;
        exp_q.push_back(mk(4'd1, 32'hAAAA0001, 5'd4, 1'b1, 1'b0, 6'd0, 1'b0));
        exp_q.push_back(mk(4'd2, 32'h11111111, 5'd3, 1'b1, 1'b0, 6'd0, 1'b0));
        exp_q.push_back(mk(4'd3, 32'h00000003, 5'd6, 1'b1, 1'b0, 6'd0, 1'b0));
        exp_q.push_back(mk(4'd4, 32'h00000000, 5'd8, 1'b0, 1'b0, 6'd0, 1'b1));
        ei = 0; mi = 0; cyc = 0;
        while ((ei < 2 || mi < 2) && cyc < 12) begin
            ex_valid_i  = (ei < 2);
            mem_valid_i = (mi < 2);
            if (ei < 2) begin ex_tag_i = ex_items[ei]; ex_data_i = ex_dat[ei]; end
            if (mi < 2) begin mem_meta_i = mem_items[mi]; mem_data_i = mem_dat[mi]; end
            @(negedge clk_i);
            ae = ex_valid_i && ex_ready_o;
            am = mem_valid_i && mem_ready_o;
            tick();
            if (ae) ei++;
            if (am) mi++;
            cyc++;
        end
        ex_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        check("rr_cycles_for_4", cyc, 4);
        repeat (2) tick();

        // EX only, GPR destination
        exp_q.push_back(mk(4'd3, 32'hA5A5A5A5, 5'd5, 1'b1, 1'b0, 6'd0, 1'b0));
        send_ex(4'd3, 5'd5, 1'b0, 32'hA5A5A5A5);
        repeat (2) tick();

        // EX with coprocessor destination: RF write pulse plus we=0 result
        exp_q.push_back(mk(4'd7, 32'h00001234, 5'd12, 1'b0, 1'b0, 6'd0, 1'b0));
        creg_q.push_back({5'd12, 32'h00001234});
        send_ex(4'd7, 5'd12, 1'b1, 32'h00001234);
        repeat (3) tick();
        check("creg_pulse_consumed", creg_q.size(), 0);

        // MEM load with exception
        exp_q.push_back(mk(4'd2, 32'h0, 5'd9, 1'b0, 1'b1, 6'd5, 1'b0));
        send_mem('{id: 4'd2, rd: 5'd9, we: 1'b1, exc: 1'b1, exccode: 6'd5, dbg: 1'b0}, 32'h0);
        repeat (2) tick();

        // Back-pressure: id=1 held for 3 cycles, id=2 waits, then both flow
        result_ready_i = 1'b0;
        exp_q.push_back(mk(4'd1, 32'h00000100, 5'd1, 1'b1, 1'b0, 6'd0, 1'b0));
        exp_q.push_back(mk(4'd2, 32'h00000200, 5'd2, 1'b1, 1'b0, 6'd0, 1'b0));
        send_ex(4'd1, 5'd1, 1'b0, 32'h00000100);
        ex_valid_i = 1'b1;
        ex_tag_i   = '{id: 4'd2, addr: 5'd2, rd_is_copro: 1'b0};
        ex_data_i  = 32'h00000200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_valid_held", result_valid_o, 1);
            check("bp_id_held", result_o.id, 4'd1);
            check("bp_ex_ready_low", ex_ready_o, 0);
            tick();
        end
        result_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_ex_ready_on_pop", ex_ready_o, 1);
        tick();
        ex_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_next_valid", result_valid_o, 1);
        check("bp_next_id", result_o.id, 4'd2);
        repeat (2) tick();

        // Reset while a result and an RF write are pending
        result_ready_i = 1'b0;
        send_ex(4'd5, 5'd7, 1'b1, 32'h00000055);
        #1;
        rst_i = 1'b1;
        #1;
        check("midrst_valid_cleared", result_valid_o, 0);
        check("midrst_creg_we", creg_we_o, 0);
        check("midrst_result", result_o, 0);
        tick();
        rst_i = 1'b0;
        result_ready_i = 1'b1;
        repeat (4) tick();

        // Fixed priority instance: MEM always wins while valid
        fp_ex_valid  = 1'b1;
        fp_ex_tag    = '{id: 4'd8, addr: 5'd1, rd_is_copro: 1'b0};
        fp_ex_data   = 32'h8;
        fp_mem_valid = 1'b1;
        fp_mem_meta  = '{id: 4'd9, rd: 5'd2, we: 1'b1, exc: 1'b0, exccode: 6'd0, dbg: 1'b0};
        fp_mem_data  = 32'h9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("fp_mem_ready", fp_mem_ready, 1);
            check("fp_ex_ready", fp_ex_ready, 0);
            if (i > 0) check("fp_result_id_mem", fp_result.id, 4'd9);
            tick();
        end
        fp_mem_valid = 1'b0;
        @(negedge clk_i);
        check("fp_ex_ready_alone", fp_ex_ready, 1);
        tick();
        fp_ex_valid = 1'b0;
        @(negedge clk_i);
        check("fp_result_ex", {fp_result_valid, fp_result.id, fp_result.data[7:0]}, {1'b1, 4'd8, 8'h08});
        check("fp_no_creg", {fp_creg_we, fp_creg_waddr, fp_creg_wdata}, 0);
        tick();

        check("exp_q_drained", exp_q.size(), 0);
        check("creg_q_drained", creg_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xif_copro_result_stage.md
Name: xif_copro_result_stage

Overview:
- Final stage of the XIF coprocessor; sits directly downstream of coprocessor execution and the memory instruction path.
- Merges two result streams into the single XIF result channel: execution results tagged with copro_tag_t, and load/store completions carrying mem_metadata_t.
- Drives the x_result_t valid/ready handshake to the core.
- Writes the coprocessor register file when the destination is a coprocessor register.

Parameters:
- ID_WIDTH, 4, offloaded instruction ID width (X_ID_WIDTH).
- DATA_WIDTH, 32, result data width (X_RFW_WIDTH).
- FIXED_PRIO, 0, 0 = round-robin between sources; 1 = memory source always wins.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- ex_valid_i  in  1  execution result valid
- ex_ready_o  out  1  execution result accepted
- ex_tag_i  in  copro_tag_t  {id, addr, rd_is_copro}
- ex_data_i  in  DATA_WIDTH  execution result data
- mem_valid_i  in  1  memory completion valid
- mem_ready_o  out  1  memory completion accepted
- mem_meta_i  in  mem_metadata_t  {id, rd, we, exc, exccode, dbg}
- mem_data_i  in  DATA_WIDTH  load data; don't-care for stores
- result_valid_o  out  1  XIF result valid
- result_ready_i  in  1  XIF result ready
- result_o  out  x_result_t  XIF result payload
- creg_we_o  out  1  coprocessor RF write enable (single-cycle pulse)
- creg_waddr_o  out  5  coprocessor RF write address
- creg_wdata_o  out  DATA_WIDTH  coprocessor RF write data

Behaviour:
- Reset (asynchronous, rst_i=1): result_valid_o=0, result_o='0, creg_we_o=0, creg_waddr_o=0, creg_wdata_o=0, RR pointer favours EX.
- Output register: one entry; slot_free = !result_valid_o | result_ready_i.
- Grant:
  - Only one source valid: that source is granted.
  - Both valid: RR grants the source not granted last. FIXED_PRIO=1 always grants MEM.
  - RR pointer updates only on an actual transfer (valid & ready).
- Readies: ex_ready_o = grant_ex & slot_free; mem_ready_o = grant_mem & slot_free. Readies may depend combinationally on valids and result_ready_i. At most one source is ready per cycle.
- Latency: an input accepted in cycle N appears with result_valid_o=1 in cycle N+1.
- Output hold: result_o and result_valid_o stay stable while result_valid_o & !result_ready_i. Back-to-back acceptance gives 1 result/cycle.
- EX mapping:
  - id=tag.id, data=ex_data_i, rd=tag.addr, we=!tag.rd_is_copro.
  - exc=0, exccode=0, dbg=0, err=0, ecswe=0, ecsdata=0.
- MEM mapping:
  - id=meta.id, rd=meta.rd, we=meta.we & !meta.exc.
  - data = meta.we ? mem_data_i : 0.
  - exc=meta.exc, exccode = meta.exc ? meta.exccode : 0, dbg=meta.dbg, err=0, ecs*=0.
- Coprocessor RF write: on EX acceptance with tag.rd_is_copro=1, creg_we_o=1 in cycle N+1 only, with creg_waddr_o=tag.addr and creg_wdata_o=ex_data_i.
  - The XIF result is still emitted, with we=0, so every offloaded instruction produces exactly one result transaction.
  - The RF write is not delayed by result_ready_i back-pressure.
- Simultaneous pop and push: when result_ready_i=1 in the same cycle as a new acceptance, the register reloads and result_valid_o stays 1.
- Reset mid-transfer: the pending result is discarded, and no creg_we_o pulse occurs after reset.
- No internal reordering: results leave in acceptance order. ID uniqueness is the upstream's responsibility.

Decomposition:
- Package xif_copro_pkg:
  - add result_src_e {SrcExec, SrcMem};
  - add copro_result_t {copro_tag_t tag; logic [X_RFW_WIDTH-1:0] data};
  - reuse x_result_t, mem_metadata_t, copro_tag_t.
- Sub-module: xif_copro_rr_arb2, a 2-requester round-robin arbiter with a registered last-grant pointer, a fixed-priority mode, and an update-on-transfer input.

Test Plan:
- EX only: tag{id=3,addr=5,copro=0}, data=0xA5A5A5A5, result_ready_i=1 -> next cycle result_valid_o=1, id=3, rd=5, we=1, data=0xA5A5A5A5, creg_we_o=0.
- EX with copro destination: tag{id=7,addr=12,copro=1}, data=0x1234 -> creg_we_o pulse 1 cycle, addr=12, wdata=0x1234; result id=7, we=0.
- MEM exception: meta{id=2,rd=9,we=1,exc=1,exccode=5} -> result we=0, exc=1, exccode=5, data=0.
- Both valid every cycle, RR mode, ready=1 -> grants alternate EX, MEM, EX, MEM; 4 results in 4 consecutive cycles. With FIXED_PRIO=1 -> MEM only while MEM stays valid.
- Back-pressure: result_ready_i=0 for 3 cycles with EX id=1 pending -> result_o stable, ex_ready_o=0, no second grant; ready=1 -> id=1 delivered and the next accepted the same cycle.
- rst_i asserted while result_valid_o=1 -> result_valid_o=0 immediately (asynchronous), creg_we_o=0, pending result never delivered.
